// File: rtl/imem_loader.sv
// imem_loader
//
// Boot-time program loader for the single-cycle RISC-V core. A little-endian
// byte stream arrives over a valid/ready handshake, is packed into 32-bit
// words and written sequentially into instruction memory starting at word
// address 0. The core is held in reset until the requested number of words
// has been written. A running sum of the written words is reported so that
// the host can verify the image.
//
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready
// are both high. byte_ready is a decode of registered state only, so it
// never depends on byte_valid in the same cycle. The producer holds byte_in
// stable while byte_valid is high and byte_ready is low.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous active-high reset
//   start        begin a load (honoured in IDLE and DONE only)
//   len_words    number of words to load, latched when start is accepted
//   byte_in      stream byte
//   byte_valid   byte_in is valid
//   byte_ready   loader accepts a byte this cycle
//   imem_we      instruction-memory write strobe (one cycle per word)
//   imem_addr    instruction-memory word address
//   imem_wdata   assembled instruction word
//   core_reset   reset to the core, released only once the load completes
//   busy         load in progress
//   done         load complete
//   words_loaded words written in the current load
//   checksum     sum mod 2^32 of the words written in the current load

module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len_words,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic [31:0]           checksum
);

  // DEPTH expressed in the len_words width: a single 1 above the address bits.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_WIDTH:0] len;
  logic [ADDR_WIDTH:0] len_next;
  logic [ADDR_WIDTH:0] word_cnt;
  logic [ADDR_WIDTH:0] word_cnt_next;
  logic [ADDR_WIDTH:0] word_cnt_inc;
  logic [1:0]          byte_cnt;
  logic [1:0]          byte_cnt_next;
  logic [31:0]         asm_word;
  logic [31:0]         asm_word_next;
  logic [31:0]         sum;
  logic [31:0]         sum_next;
  logic [ADDR_WIDTH:0] len_clamped;

  // Requests beyond the memory size are clamped so the address never wraps.
  assign len_clamped  = (len_words > DEPTH_W) ? DEPTH_W : len_words;
  assign word_cnt_inc = word_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      len      <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_word <= '0;
      sum      <= '0;
    end else begin
      state    <= state_next;
      len      <= len_next;
      word_cnt <= word_cnt_next;
      byte_cnt <= byte_cnt_next;
      asm_word <= asm_word_next;
      sum      <= sum_next;
    end
  end

  always_comb begin
    state_next    = state;
    len_next      = len;
    word_cnt_next = word_cnt;
    byte_cnt_next = byte_cnt;
    asm_word_next = asm_word;
    sum_next      = sum;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          len_next      = len_clamped;
          word_cnt_next = '0;
          byte_cnt_next = '0;
          asm_word_next = '0;
          sum_next      = '0;
          state_next    = (len_clamped == '0) ? DONE : RECV;
        end
      end

      RECV: begin
        if (byte_valid) begin
          // Little-endian packing: the first byte of a word is the LSB.
          asm_word_next[{byte_cnt, 3'b000} +: 8] = byte_in;
          byte_cnt_next = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            state_next = WRITE;
          end
        end
      end

      WRITE: begin
        sum_next      = sum + asm_word;
        word_cnt_next = word_cnt_inc;
        byte_cnt_next = '0;
        state_next    = (word_cnt_inc == len) ? DONE : RECV;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Every output is a decode of registered state.
  assign byte_ready   = (state == RECV);
  assign imem_we      = (state == WRITE);
  assign imem_addr    = word_cnt[ADDR_WIDTH-1:0];
  assign imem_wdata   = asm_word;
  assign core_reset   = (state != DONE);
  assign busy         = (state == RECV) || (state == WRITE);
  assign done         = (state == DONE);
  assign words_loaded = word_cnt;
  assign checksum     = sum;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed scenarios plus randomized loads, with
// a queue-based reference model of the load process checked every cycle.

module tb_imem_loader;

  localparam int AW    = 4;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 2 ** AW;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          reset;
  logic          start;
  logic [AW:0]   len_words;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_reset;
  logic          busy;
  logic          done;
  logic [AW:0]   words_loaded;
  logic [31:0]   checksum;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .len_words    (len_words),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .busy         (busy),
    .done         (done),
    .words_loaded (words_loaded),
    .checksum     (checksum)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  // A load is "active" while words remain; the current word is the queue of
  // bytes gathered so far, and a full queue means the write happens now.
  logic [7:0]  m_bytes[$];
  bit          m_active   = 1'b0;
  bit          m_finished = 1'b0;
  int          m_len      = 0;
  int          m_words    = 0;
  logic [31:0] m_sum      = '0;
  logic [31:0] model_mem[DEPTH];

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0; m_finished = 1'b0; m_len = 0; m_words = 0; m_sum = '0;
      m_bytes.delete();
    end else if (!m_active) begin
      if (start) begin
        m_len      = (int'(len_words) > DEPTH) ? DEPTH : int'(len_words);
        m_words    = 0;
        m_sum      = '0;
        m_bytes.delete();
        m_finished = (m_len == 0);
        m_active   = (m_len != 0);
      end
    end else if (m_bytes.size() == 4) begin
      model_mem[m_words] = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      m_sum = m_sum + {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      m_words++;
      m_bytes.delete();
      if (m_words == m_len) begin
        m_active = 1'b0; m_finished = 1'b1;
      end
    end else if (byte_valid) begin
      m_bytes.push_back(byte_in);
    end
  end

  // Record of every write the DUT actually performs.
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [31:0] dut_mem[DEPTH];
  always @(posedge clk) begin
    if (imem_we) begin
      log_addr.push_back(32'(imem_addr));
      log_data.push_back(imem_wdata);
      dut_mem[imem_addr] = imem_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;
  logic [7:0] tx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic compare_cycle();
    bit exp_we;
    exp_we = m_active && (m_bytes.size() == 4);
    check("byte_ready", 32'(byte_ready), 32'(m_active && (m_bytes.size() < 4)));
    check("imem_we", 32'(imem_we), 32'(exp_we));
    check("core_reset", 32'(core_reset), 32'(!m_finished));
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_finished));
    check("words_loaded", 32'(words_loaded), 32'(m_words));
    check("checksum", checksum, m_sum);
    if (exp_we) begin
      check("imem_addr", 32'(imem_addr), 32'(m_words));
      check("imem_wdata", imem_wdata, {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    start     = 1'b1;
    len_words = LW'(len);
    tick();
    start     = 1'b0;
  endtask

  // mode 0: valid every cycle, 1: every other cycle, 2: random with start noise
  task automatic send(input int mode);
    int   guard;
    bit   phase;
    bit   v;
    logic rdy;
    guard = 0;
    phase = 1'b1;
    while (tx_q.size() > 0 && guard < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = phase; phase = ~phase; end
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      byte_valid = v;
      byte_in    = v ? tx_q[0] : 8'($urandom);
      if (mode == 2) begin
        start     = ($urandom_range(0, 9) == 0);
        len_words = LW'($urandom_range(0, 31));
      end
      rdy = byte_ready;
      tick();
      if (v && rdy) void'(tx_q.pop_front());
      guard++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    check("send_drained", 32'(tx_q.size()), 32'd0);
    tx_q.delete();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !done; i++) tick();
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      byte_valid = ($urandom_range(0, 1) == 1);
      byte_in    = 8'($urandom);
      tick();
    end
    byte_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int t_start;
  int base;
  int len;
  int eff;
  int nb;

  initial begin
    reset = 1'b1; start = 1'b0; len_words = '0; byte_in = '0; byte_valid = 1'b0;
    do_reset();
    chk_en = 1'b1;

    // Reset values.
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_checksum", checksum, 32'd0);
    idle_noise(3);

    // Two words, back-to-back bytes.
    base = log_addr.size();
    pulse_start(2);
    t_start = cyc;
    check("t1_ready_after_start", 32'(byte_ready), 32'd1);
    tx_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send(0);
    wait_done();
    check("t1_done_latency", 32'(cyc - t_start), 32'd10);
    check("t1_checksum", checksum, 32'h006000A6);
    check("t1_model_sum", m_sum, 32'h006000A6);
    check("t1_words_loaded", 32'(words_loaded), 32'd2);
    check("t1_core_reset", 32'(core_reset), 32'd0);
    check("t1_nwrites", 32'(log_addr.size() - base), 32'd2);
    check("t1_w0_addr", log_addr[base], 32'd0);
    check("t1_w0_data", log_data[base], 32'h00500013);
    check("t1_w1_addr", log_addr[base+1], 32'd1);
    check("t1_w1_data", log_data[base+1], 32'h00100093);

    // Same image, byte_valid every other cycle, restarted from DONE.
    base = log_addr.size();
    pulse_start(2);
    tx_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send(1);
    wait_done();
    check("t2_checksum", checksum, 32'h006000A6);
    check("t2_nwrites", 32'(log_addr.size() - base), 32'd2);
    check("t2_w0_data", log_data[base], 32'h00500013);
    check("t2_w1_data", log_data[base+1], 32'h00100093);

    // Zero-length load.
    base = log_addr.size();
    pulse_start(0);
    check("t3_done", 32'(done), 32'd1);
    check("t3_core_reset", 32'(core_reset), 32'd0);
    check("t3_words_loaded", 32'(words_loaded), 32'd0);
    idle_noise(3);
    check("t3_nwrites", 32'(log_addr.size() - base), 32'd0);

    // Partial word, ignored start, then reset together with start.
    base = log_addr.size();
    pulse_start(1);
    tx_q = '{8'h11, 8'h22};
    send(0);
    start = 1'b1; len_words = LW'(3);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    check("t4_core_reset", 32'(core_reset), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_nwrites", 32'(log_addr.size() - base), 32'd0);
    pulse_start(1);
    tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send(0);
    wait_done();
    check("t4_nwrites_after", 32'(log_addr.size() - base), 32'd1);
    check("t4_addr", log_addr[base], 32'd0);
    check("t4_data", log_data[base], 32'hDDCCBBAA);

    // Restart from DONE clears the counters immediately.
    base = log_addr.size();
    pulse_start(1);
    check("t5_done", 32'(done), 32'd0);
    check("t5_core_reset", 32'(core_reset), 32'd1);
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_words_loaded", 32'(words_loaded), 32'd0);
    check("t5_checksum", checksum, 32'd0);
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send(0);
    wait_done();
    check("t5_addr", log_addr[base], 32'd0);
    check("t5_data", log_data[base], 32'h04030201);

    // Oversized request is clamped to the memory depth.
    base = log_addr.size();
    pulse_start(31);
    for (int i = 0; i < DEPTH * 4; i++) tx_q.push_back(8'($urandom));
    send(0);
    wait_done();
    check("t6_words_loaded", 32'(words_loaded), 32'(DEPTH));
    check("t6_nwrites", 32'(log_addr.size() - base), 32'(DEPTH));
    check("t6_last_addr", log_addr[log_addr.size()-1], 32'(DEPTH - 1));

    // Randomized loads, some aborted by reset partway through.
    for (int it = 0; it < 12; it++) begin
      len = $urandom_range(0, 20);
      eff = (len > DEPTH) ? DEPTH : len;
      pulse_start(len);
      if (eff > 0 && $urandom_range(0, 3) == 0) begin
        nb = $urandom_range(1, eff * 4 - 1);
        for (int i = 0; i < nb; i++) tx_q.push_back(8'($urandom));
        send(0);
        do_reset();
      end else begin
        for (int i = 0; i < eff * 4; i++) tx_q.push_back(8'($urandom));
        send(2);
        wait_done();
        check("rnd_words_loaded", 32'(words_loaded), 32'(eff));
      end
      idle_noise($urandom_range(1, 4));
    end

    // Memory image built from DUT writes must match the model's image.
    for (int i = 0; i < DEPTH; i++) check("mem_image", dut_mem[i], model_mem[i]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
